// File: rtl/bitfusion_pkg.sv
// Shared constants, mode encodings and FSM state type for the BitFusion input path.
package bitfusion_pkg;

  localparam int BRICK_W = 2;
  localparam int SLICE_W = 32;

  localparam logic [1:0] MODE_8B = 2'b00;
  localparam logic [1:0] MODE_4B = 2'b01;
  localparam logic [1:0] MODE_2B = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } fsm_state_t;

  // Number of beats a word occupies on the output for a given weight mode.
  // Both 2'b10 and 2'b11 mean 2-bit weights.
  function automatic logic [2:0] nbeats(input logic [1:0] mode);
    case (mode)
      MODE_8B: return 3'd1;
      MODE_4B: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/brick_slice_mux.sv
// Combinational brick sorter/replicator for one 32-bit slice of the held word.
module brick_slice_mux
  import bitfusion_pkg::*;
(
  input  logic [SLICE_W-1:0] slice,
  input  logic [1:0]         mode,
  input  logic [1:0]         beat,
  output logic [SLICE_W-1:0] out
);

  logic [7:0] src_byte;

  // Select the source byte(s) for this beat and replicate the bricks into place.
  always_comb begin
    out      = '0;
    src_byte = '0;
    case (mode)
      MODE_8B: begin
        out = slice;
      end
      MODE_4B: begin
        // Nibble j takes brick j/2 of byte (2*beat + j%2), replicated twice.
        for (int j = 0; j < 8; j++) begin
          src_byte        = slice[{beat[0], j[0], 3'b000} +: 8];
          out[4*j +: 4]   = {2{src_byte[BRICK_W*(j/2) +: BRICK_W]}};
        end
      end
      default: begin
        // Byte i takes brick i of byte `beat`, replicated four times.
        src_byte = slice[{beat, 3'b000} +: 8];
        for (int i = 0; i < 4; i++) begin
          out[8*i +: 8] = {4{src_byte[BRICK_W*i +: BRICK_W]}};
        end
      end
    endcase
  end

endmodule

// File: rtl/input_unpack_sequencer.sv
// Sequencing input unpacker: holds one packed word and emits 1/2/4 brick beats
// towards the PE array depending on the weight bitwidth latched with the word.
//
// Handshakes: a transfer happens on a side exactly in the cycle where its
// valid and ready are both high at the clock edge. out_valid never depends on
// out_ready; in_ready depends combinationally on out_ready and flush so that a
// new word can be taken in the same cycle the last beat of the old word leaves.
module input_unpack_sequencer
  import bitfusion_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        weight_bitwidth,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_beat,
  output logic              out_last,
  output logic              busy,
  output fsm_state_t        state_dbg
);

  localparam int NSLICE = DATA_W / SLICE_W;

  fsm_state_t        state_q, state_n;
  logic [DATA_W-1:0] word_q, word_n;
  logic [1:0]        mode_q, mode_n;
  logic [1:0]        beat_q, beat_n;

  logic              last_beat;
  logic              in_fire;
  logic              out_fire;
  logic [DATA_W-1:0] mux_out;

  assign last_beat = (state_q == ST_EMIT) && ({1'b0, beat_q} == (nbeats(mode_q) - 3'd1));
  assign in_ready  = !flush && ((state_q == ST_IDLE) || (out_ready && last_beat));
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // State, held word, latched mode and beat counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      mode_q  <= MODE_8B;
      beat_q  <= 2'd0;
    end else begin
      state_q <= state_n;
      word_q  <= word_n;
      mode_q  <= mode_n;
      beat_q  <= beat_n;
    end
  end

  // Next-state logic: flush beats everything, then accept, then beat advance.
  always_comb begin
    state_n = state_q;
    word_n  = word_q;
    mode_n  = mode_q;
    beat_n  = beat_q;
    if (flush) begin
      state_n = ST_IDLE;
      word_n  = '0;
      mode_n  = MODE_8B;
      beat_n  = 2'd0;
    end else if (in_fire) begin
      state_n = ST_EMIT;
      word_n  = in_data;
      mode_n  = weight_bitwidth;
      beat_n  = 2'd0;
    end else if (out_fire) begin
      if (last_beat) begin
        state_n = ST_IDLE;
        beat_n  = 2'd0;
      end else begin
        beat_n  = beat_q + 2'd1;
      end
    end
  end

  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    brick_slice_mux u_mux (
      .slice (word_q[SLICE_W*s +: SLICE_W]),
      .mode  (mode_q),
      .beat  (beat_q),
      .out   (mux_out[SLICE_W*s +: SLICE_W])
    );
  end

  // Outputs come only from registers and read as zero while nothing is held.
  always_comb begin
    out_valid = (state_q == ST_EMIT);
    busy      = out_valid;
    out_data  = out_valid ? mux_out : '0;
    out_beat  = out_valid ? beat_q : 2'd0;
    out_last  = last_beat;
    state_dbg = state_q;
  end

endmodule
